mult_issue_ctrl: RTL and testbench

//  Requester-side sequencer for the 8x8 shift-add multiplier core.

---
 rtl/mult_pkg.sv | 15 +
 rtl/mult_issue_ctrl.sv | 92 +++++++++
 tb/tb_mult_issue_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier slice: default operand width and the
// state encodings shared by every state_out debug bus.
package mult_pkg;

  localparam int MULT_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_START = 3'b001,
    ST_WAIT  = 3'b010,
    ST_HOLD  = 3'b011,
    ST_ERR   = 3'b100
  } mult_state_e;

endpackage

// File: rtl/mult_issue_ctrl.sv
// Requester-side sequencer for the shift-add multiplier core: latches one operand
// pair, pulses core_start, waits for core_done (bounded), returns the product.
module mult_issue_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH   = MULT_WIDTH,
  parameter int TIMEOUT = 8,
  parameter int TCNT_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset_a,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 core_start,
  output logic [WIDTH-1:0]     core_dataa,
  output logic [WIDTH-1:0]     core_datab,
  input  logic                 core_done,
  input  logic [2*WIDTH-1:0]   core_product,
  input  logic                 err_clr,
  output logic                 err,
  output logic [2:0]           state_out
);

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  mult_state_e       state;
  mult_state_e       next_state;
  logic [TCNT_W-1:0] tcnt;

  always_comb begin
    // NOTE: default first so every path assigns next_state; a missed branch would infer a latch.
    next_state = state;
    case (state)
      ST_IDLE:  if (in_valid) next_state = ST_START;
      ST_START: next_state = ST_WAIT;
      // done is checked before the timeout so a last-cycle answer still wins
      ST_WAIT: begin
        if (core_done)               next_state = ST_HOLD;
        else if (tcnt >= TCNT_LAST)  next_state = ST_ERR;
      end
      ST_HOLD:  if (out_ready) next_state = ST_IDLE;
      ST_ERR:   if (err_clr)   next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset_a) begin
      state <= ST_IDLE;
      tcnt  <= '0;
    end else begin
      state <= next_state;
      if (state == ST_START)
        tcnt <= '0;
      else if (state == ST_WAIT && tcnt != '1)
        tcnt <= tcnt + 1'b1;
    end
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset_a) begin
      in_ready    <= 1'b1;
      core_start  <= 1'b0;
      out_valid   <= 1'b0;
      err         <= 1'b0;
      out_product <= '0;
      core_dataa  <= '0;
      core_datab  <= '0;
    end else begin
      in_ready   <= (next_state == ST_IDLE);
      core_start <= (next_state == ST_START);
      out_valid  <= (next_state == ST_HOLD);
      err        <= (next_state == ST_ERR);
      if (state == ST_IDLE && in_valid) begin
        core_dataa <= in_a;
        core_datab <= in_b;
      end
      if (state == ST_WAIT && core_done)
        out_product <= core_product;
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Self-checking bench for mult_issue_ctrl with a behavioural core of programmable
// done latency; expectations come from transaction-level rules.
module tb_mult_issue_ctrl;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 8;

  logic               clk = 1'b0;
  logic               reset_a;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;
  logic               core_start;
  logic [WIDTH-1:0]   core_dataa;
  logic [WIDTH-1:0]   core_datab;
  logic               core_done;
  logic [2*WIDTH-1:0] core_product;
  logic               err_clr;
  logic               err;
  logic [2:0]         state_out;

  int total = 0;
  int bad   = 0;

  mult_issue_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .TCNT_W(4)) dut (
    .clk(clk), .reset_a(reset_a),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .core_start(core_start), .core_dataa(core_dataa), .core_datab(core_datab),
    .core_done(core_done), .core_product(core_product),
    .err_clr(err_clr), .err(err), .state_out(state_out)
  );

  always #5 clk = ~clk;

  // Behavioural core: done pulses core_delay cycles after the start pulse is seen;
  // it ignores reset_a so a late answer can arrive after the requester was reset.
  int unsigned        core_delay = 5;
  bit                 core_never = 1'b0;
  logic               core_busy  = 1'b0;
  int unsigned        core_cnt   = 0;
  logic [2*WIDTH-1:0] core_res   = '0;

  always @(posedge clk) begin
    if (core_start) begin
      core_busy <= 1'b1;
      core_cnt  <= core_delay;
      core_res  <= (2*WIDTH)'(core_dataa) * (2*WIDTH)'(core_datab);
    end else if (core_busy) begin
      if (core_cnt == 0) core_busy <= 1'b0;
      else               core_cnt  <= core_cnt - 1;
    end
  end

  assign core_done    = core_busy && (core_cnt == 0) && !core_never;
  assign core_product = core_done ? core_res : ~core_res;

  // Transaction-level reference: a done arriving on WAIT cycle d (0-based) is
  // accepted if it is within the TIMEOUT-cycle window, otherwise the op errors.
  function automatic bit ref_times_out(int unsigned d, bit never);
    return never || (d >= TIMEOUT);
  endfunction

  function automatic int ref_wait_ticks(int unsigned d, bit never);
    return ref_times_out(d, never) ? TIMEOUT : int'(d) + 1;
  endfunction

  function automatic logic [31:0] ref_product(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    return 32'(a) * 32'(b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until out_valid (or err) rises, bounded; the count is checked by the caller.
  task automatic wait_event(input bit want_err, output int n);
    n = 0;
    while (!(want_err ? err : out_valid) && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic check_idle(string tag);
    check({tag, "_state"}, 32'(state_out), 32'h0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'h1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
  endtask

  task automatic accept_product(string tag, int unsigned stall, logic [31:0] exp);
    out_ready = 1'b0;
    for (int i = 0; i < int'(stall); i++) begin
      tick();
      check({tag, "_stall_valid"}, 32'(out_valid), 32'h1);
      check({tag, "_stall_prod"}, 32'(out_product), exp);
      check({tag, "_stall_in_ready"}, 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_idle({tag, "_after"});
  endtask

  task automatic do_op(string tag, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                       int unsigned d, bit never, int unsigned stall);
    int n;
    bit to;
    to = ref_times_out(d, never);
    core_delay = d;
    core_never = never;
    check({tag, "_pre_ready"}, 32'(in_ready), 32'h1);
    in_a = a; in_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a = WIDTH'($urandom);
    in_b = WIDTH'($urandom);
    check({tag, "_start_state"}, 32'(state_out), 32'h1);
    check({tag, "_start_pulse"}, 32'(core_start), 32'h1);
    check({tag, "_dataa"}, 32'(core_dataa), 32'(a));
    check({tag, "_datab"}, 32'(core_datab), 32'(b));
    check({tag, "_start_in_ready"}, 32'(in_ready), 32'h0);
    tick();
    check({tag, "_wait_state"}, 32'(state_out), 32'h2);
    check({tag, "_pulse_end"}, 32'(core_start), 32'h0);
    wait_event(to, n);
    check({tag, "_latency"}, 32'(n), 32'(ref_wait_ticks(d, never)));
    check({tag, "_dataa_held"}, 32'(core_dataa), 32'(a));
    if (to) begin
      check({tag, "_err_state"}, 32'(state_out), 32'h4);
      check({tag, "_err_valid"}, 32'(out_valid), 32'h0);
      check({tag, "_err_in_ready"}, 32'(in_ready), 32'h0);
      in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      check({tag, "_err_sticky"}, 32'(err), 32'h1);
      check({tag, "_err_ignore_in"}, 32'(state_out), 32'h4);
      check({tag, "_err_no_start"}, 32'(core_start), 32'h0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check_idle({tag, "_clr"});
    end else begin
      check({tag, "_hold_state"}, 32'(state_out), 32'h3);
      check({tag, "_product"}, 32'(out_product), ref_product(a, b));
      check({tag, "_no_err"}, 32'(err), 32'h0);
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'h0);
      accept_product(tag, stall, ref_product(a, b));
    end
  endtask

  initial begin
    int n;
    logic [WIDTH-1:0] ra, rb;
    int unsigned rd, rs;

    reset_a = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b0; err_clr = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_core_start", 32'(core_start), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_product", 32'(out_product), 32'h0);
    check("rst_state", 32'(state_out), 32'h0);
    reset_a = 1'b0;
    tick();

    do_op("t1_ff", 8'hFF, 8'hFF, 5, 1'b0, 0);
    do_op("t2_stall", 8'h12, 8'h34, 5, 1'b0, 3);
    do_op("t3_timeout", 8'h21, 8'h43, 0, 1'b1, 0);
    do_op("t4_last_cycle", 8'h9C, 8'h77, TIMEOUT - 1, 1'b0, 1);

    // err_clr outside ERR has no effect
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_idle("clr_in_idle");

    // Reset in the middle of WAIT; the core's late done must be ignored.
    core_delay = 5; core_never = 1'b0;
    in_a = 8'hC3; in_b = 8'h5A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("t5_pre_rst_wait", 32'(state_out), 32'h2);
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    check_idle("t5_rst");
    check("t5_rst_product", 32'(out_product), 32'h0);
    check("t5_rst_dataa", 32'(core_dataa), 32'h0);
    check("t5_rst_datab", 32'(core_datab), 32'h0);
    check("t5_rst_start", 32'(core_start), 32'h0);
    for (int i = 0; i < 5; i++) tick();
    check_idle("t5_late_done");
    check("t5_late_product", 32'(out_product), 32'h0);
    do_op("t5_new", 8'h03, 8'h05, 5, 1'b0, 0);

    // Back-to-back: in_valid held high across two operations.
    core_delay = 5; core_never = 1'b0;
    in_a = 8'h0A; in_b = 8'h0B; in_valid = 1'b1;
    tick();
    in_a = 8'h10; in_b = 8'h10;
    check("t6_first_dataa", 32'(core_dataa), 32'h0A);
    tick();
    wait_event(1'b0, n);
    check("t6_first_latency", 32'(n), 32'(ref_wait_ticks(5, 1'b0)));
    check("t6_first_product", 32'(out_product), ref_product(8'h0A, 8'h0B));
    check("t6_first_not_requeued", 32'(core_dataa), 32'h0A);
    check("t6_hold_in_ready", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t6_idle_between", 32'(state_out), 32'h0);
    check("t6_ready_between", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    check("t6_second_start", 32'(state_out), 32'h1);
    check("t6_second_dataa", 32'(core_dataa), 32'h10);
    tick();
    wait_event(1'b0, n);
    check("t6_second_latency", 32'(n), 32'(ref_wait_ticks(5, 1'b0)));
    check("t6_second_product", 32'(out_product), ref_product(8'h10, 8'h10));
    accept_product("t6_second", 0, ref_product(8'h10, 8'h10));

    // Randomized operations, including late answers that must time out.
    for (int k = 0; k < 20; k++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rd = $urandom_range(0, TIMEOUT + 2);
      rs = $urandom_range(0, 3);
      do_op("rand", ra, rb, rd, 1'b0, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
